phy_rx_fifo: RTL and testbench



---
 rtl/phy_rx_pkg.sv | 10 +
 rtl/phy_rx_fifo_mem.sv | 24 ++
 rtl/phy_rx_fifo.sv | 105 ++++++++++
 tb/tb_phy_rx_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/phy_rx_pkg.sv
// phy_rx_pkg: shared defaults, link state encoding and pointer-width helper for phy_rx_fifo
package phy_rx_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int IDLE_TIMEOUT = 16;
  typedef enum logic {LINK_IDLE, LINK_ACTIVE} link_state_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/phy_rx_fifo_mem.sv
// phy_rx_fifo_mem: DEPTH x DATA_WIDTH storage, one synchronous write port, registered read port
module phy_rx_fifo_mem #(
  parameter int DATA_WIDTH = phy_rx_pkg::DATA_WIDTH,
  parameter int DEPTH = phy_rx_pkg::DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               we,
  input  logic [phy_rx_pkg::ptr_w(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]              wdata,
  input  logic                               re,
  input  logic [phy_rx_pkg::ptr_w(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]              rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  // A read and write to the same slot in one cycle returns the old word (full FIFO push+pop)
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/phy_rx_fifo.sv
// phy_rx_fifo: receive FIFO behind the phy with occupancy flags, sticky errors and link activity
// Optional rx_word_total push counter enabled by PHY_RX_FIFO_STATS_EN.
module phy_rx_fifo #(
  parameter int DATA_WIDTH = phy_rx_pkg::DATA_WIDTH,
  parameter int DEPTH = phy_rx_pkg::DEPTH,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2,
  parameter int IDLE_TIMEOUT = phy_rx_pkg::IDLE_TIMEOUT
) (
  input  logic                       clk_f,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      data_final,
  input  logic                       valid_final,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       valid_out,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     word_count,
  output logic                       overflow_err,
  output logic                       underflow_err,
  output logic                       link_active
`ifdef PHY_RX_FIFO_STATS_EN
  ,
  output logic [15:0]                rx_word_total
`endif
);
  import phy_rx_pkg::*;
  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_nxt;
  logic          pop_ok, push;
  logic [IW-1:0] idle_cnt;
  link_state_t   state;
  assign pop_ok  = pop && !fifo_empty;
  assign push    = valid_final && (!fifo_full || pop_ok);
  assign cnt_nxt = word_count + CW'(push) - CW'(pop_ok);
  phy_rx_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk_f),
    .rst(reset),
    .we(push),
    .waddr(wr_ptr),
    .wdata(data_final),
    .re(pop_ok),
    .raddr(rd_ptr),
    .rdata(data_out)
  );
  // Flags are computed from the next count so they match word_count after every edge
  always_ff @(posedge clk_f) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      word_count    <= '0;
      valid_out     <= 1'b0;
      fifo_full     <= 1'b0;
      fifo_empty    <= 1'b1;
      almost_full   <= 1'b0;
      almost_empty  <= 1'b1;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      word_count   <= cnt_nxt;
      valid_out    <= pop_ok;
      fifo_full    <= cnt_nxt == CW'(DEPTH);
      fifo_empty   <= cnt_nxt == '0;
      almost_full  <= cnt_nxt >= CW'(AF_THRESH);
      almost_empty <= cnt_nxt <= CW'(AE_THRESH);
      if (valid_final && fifo_full && !pop) overflow_err <= 1'b1;
      if (pop && fifo_empty) underflow_err <= 1'b1;
    end
  end
  always_ff @(posedge clk_f) begin
    if (reset) begin
      state       <= LINK_IDLE;
      idle_cnt    <= '0;
      link_active <= 1'b0;
    end else if (state == LINK_IDLE) begin
      if (valid_final) begin
        state       <= LINK_ACTIVE;
        link_active <= 1'b1;
        idle_cnt    <= '0;
      end
    end else if (valid_final) begin
      idle_cnt <= '0;
    end else if (idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
      state       <= LINK_IDLE;
      link_active <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`ifdef PHY_RX_FIFO_STATS_EN
  always_ff @(posedge clk_f) begin
    if (reset) rx_word_total <= '0;
    else if (push && rx_word_total != 16'hFFFF) rx_word_total <= rx_word_total + 1'b1;
  end
`endif
endmodule

// File: tb/tb_phy_rx_fifo.sv
// tb_phy_rx_fifo: directed and randomized checks of phy_rx_fifo against a queue-based model
module tb_phy_rx_fifo;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;
  localparam int IT = 16;
  logic        clk_f = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_final = '0;
  logic        valid_final = 1'b0;
  logic        pop = 1'b0;
  logic [31:0] data_out;
  logic        valid_out, fifo_full, fifo_empty, almost_full, almost_empty;
  logic [3:0]  word_count;
  logic        overflow_err, underflow_err, link_active;
`ifdef PHY_RX_FIFO_STATS_EN
  logic [15:0] rx_word_total;
`endif
  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  logic        m_valid;
  logic [31:0] m_data;
  bit          m_ovf, m_unf, m_seen;
  int          idle_run, m_total;
  phy_rx_fifo dut (
    .clk_f(clk_f),
    .reset(reset),
    .data_final(data_final),
    .valid_final(valid_final),
    .pop(pop),
    .data_out(data_out),
    .valid_out(valid_out),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .word_count(word_count),
    .overflow_err(overflow_err),
    .underflow_err(underflow_err),
    .link_active(link_active)
`ifdef PHY_RX_FIFO_STATS_EN
    ,
    .rx_word_total(rx_word_total)
`endif
  );
  always #5 clk_f = ~clk_f;
  wire [7:0] dut_flags = {valid_out, fifo_full, fifo_empty, almost_full, almost_empty,
                          overflow_err, underflow_err, link_active};
  function automatic logic [7:0] m_flags();
    int n = q.size();
    return {m_valid, n == D, n == 0, n >= AF, n <= AE, m_ovf, m_unf, m_seen && idle_run < IT};
  endfunction
  // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit after it
  task automatic step(input bit r, input bit v, input logic [31:0] d, input bit p);
    bit full, empty, pop_ok, push;
    reset = r; valid_final = v; data_final = d; pop = p;
    @(posedge clk_f);
    if (r) begin
      q.delete(); m_valid = 0; m_data = '0; m_ovf = 0; m_unf = 0;
      m_seen = 0; idle_run = 0; m_total = 0;
    end else begin
      full = q.size() == D;
      empty = q.size() == 0;
      pop_ok = p && !empty;
      push = v && (!full || pop_ok);
      m_valid = pop_ok;
      if (pop_ok) m_data = q.pop_front();
      if (push) begin
        q.push_back(d);
        if (m_total < 16'hFFFF) m_total++;
      end
      if (v && full && !p) m_ovf = 1;
      if (p && empty) m_unf = 1;
      if (v) begin m_seen = 1; idle_run = 0; end
      else if (m_seen && idle_run < IT) idle_run++;
    end
    #1;
    reset = 0; valid_final = 0; pop = 0;
  endtask
  task automatic test_reset();
    step(1, 0, 0, 0);
    checks++;
    if (dut_flags !== 8'b0010_1000) begin errors++; $display("FAIL reset_flags got=%b exp=%b", dut_flags, 8'b0010_1000); end
    checks++;
    if (word_count !== 4'd0 || data_out !== 32'd0) begin errors++; $display("FAIL reset_data count=%0d data=%h exp 0/0", word_count, data_out); end
  endtask
  task automatic test_fill_drain();
    step(1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) step(0, 1, i, 0);
    checks++;
    if (word_count !== 4'd3) begin errors++; $display("FAIL fill_count got=%0d exp=3", word_count); end
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 1);
      checks++;
      if (valid_out !== 1'b1 || data_out !== 32'(i)) begin errors++; $display("FAIL drain_%0d valid=%b data=%h exp 1/%h", i, valid_out, data_out, 32'(i)); end
    end
    step(0, 0, 0, 0);
    checks++;
    if (fifo_empty !== 1'b1 || valid_out !== 1'b0 || data_out !== 32'd3) begin errors++; $display("FAIL drain_end empty=%b valid=%b data=%h exp 1/0/3", fifo_empty, valid_out, data_out); end
  endtask
  task automatic test_overflow();
    step(1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      step(0, 1, i, 0);
      if (i == 8) begin
        checks++;
        if (fifo_full !== 1'b1 || overflow_err !== 1'b0 || word_count !== 4'd8) begin errors++; $display("FAIL ovf_full full=%b ovf=%b count=%0d exp 1/0/8", fifo_full, overflow_err, word_count); end
      end
    end
    checks++;
    if (overflow_err !== 1'b1 || word_count !== 4'd8) begin errors++; $display("FAIL ovf_flag ovf=%b count=%0d exp 1/8", overflow_err, word_count); end
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 1);
      checks++;
      if (valid_out !== 1'b1 || data_out !== 32'(i)) begin errors++; $display("FAIL ovf_drain_%0d valid=%b data=%h exp 1/%h", i, valid_out, data_out, 32'(i)); end
    end
    checks++;
    if (fifo_empty !== 1'b1 || overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_end empty=%b ovf=%b exp 1/1", fifo_empty, overflow_err); end
  endtask
  task automatic test_full_push_pop();
    step(1, 0, 0, 0);
    for (int i = 0; i < D; i++) step(0, 1, 32'h100 + i, 0);
    step(0, 1, 32'hCAFEBABE, 1);
    checks++;
    if (overflow_err !== 1'b0 || word_count !== 4'd8 || fifo_full !== 1'b1) begin errors++; $display("FAIL fullpp_state ovf=%b count=%0d full=%b exp 0/8/1", overflow_err, word_count, fifo_full); end
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h100) begin errors++; $display("FAIL fullpp_first valid=%b data=%h exp 1/00000100", valid_out, data_out); end
    for (int i = 1; i < D; i++) step(0, 0, 0, 1);
    checks++;
    if (data_out !== 32'h107) begin errors++; $display("FAIL fullpp_mid data=%h exp 00000107", data_out); end
    step(0, 0, 0, 1);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'hCAFEBABE || fifo_empty !== 1'b1) begin errors++; $display("FAIL fullpp_last valid=%b data=%h empty=%b exp 1/cafebabe/1", valid_out, data_out, fifo_empty); end
  endtask
  task automatic test_underflow();
    step(1, 0, 0, 0);
    step(0, 1, 32'h5A5A5A5A, 1);
    checks++;
    if (underflow_err !== 1'b1 || valid_out !== 1'b0 || word_count !== 4'd1) begin errors++; $display("FAIL unf_flag unf=%b valid=%b count=%0d exp 1/0/1", underflow_err, valid_out, word_count); end
    step(0, 0, 0, 1);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h5A5A5A5A || underflow_err !== 1'b1) begin errors++; $display("FAIL unf_read valid=%b data=%h unf=%b exp 1/5a5a5a5a/1", valid_out, data_out, underflow_err); end
  endtask
  task automatic test_link();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (link_active !== 1'b0) begin errors++; $display("FAIL link_idle got=%b exp=0", link_active); end
    step(0, 1, 32'h77, 0);
    checks++;
    if (link_active !== 1'b1) begin errors++; $display("FAIL link_rise got=%b exp=1", link_active); end
    for (int i = 1; i <= IT; i++) begin
      step(0, 0, 0, 0);
      if (i == IT - 1) begin
        checks++;
        if (link_active !== 1'b1) begin errors++; $display("FAIL link_hold got=%b exp=1", link_active); end
      end
    end
    checks++;
    if (link_active !== 1'b0 || word_count !== 4'd1) begin errors++; $display("FAIL link_fall link=%b count=%0d exp 0/1", link_active, word_count); end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 1, i, 0);
    step(1, 1, 32'hDEAD, 1);
    checks++;
    if (word_count !== 4'd0 || overflow_err !== 1'b0 || underflow_err !== 1'b0 || link_active !== 1'b0 || fifo_empty !== 1'b1) begin
      errors++; $display("FAIL link_reset count=%0d ovf=%b unf=%b link=%b empty=%b exp 0/0/0/0/1", word_count, overflow_err, underflow_err, link_active, fifo_empty);
    end
  endtask
  task automatic test_random();
    int vb, pb;
    step(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      vb = (i / 100) % 3 == 0 ? 80 : ((i / 100) % 3 == 1 ? 30 : 55);
      pb = (i / 100) % 3 == 0 ? 30 : ((i / 100) % 3 == 1 ? 80 : 50);
      if (i % 150 == 120) for (int k = 0; k < 20; k++) step(0, 0, 0, $urandom_range(0, 3) == 0);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < vb, $urandom, $urandom_range(0, 99) < pb);
      checks++;
      if (dut_flags !== m_flags() || word_count !== 4'(q.size()) || data_out !== m_data) begin
        errors++;
        $display("FAIL rand_%0d flags=%b/%b count=%0d/%0d data=%h/%h (got/exp)", i, dut_flags, m_flags(), word_count, q.size(), data_out, m_data);
      end
`ifdef PHY_RX_FIFO_STATS_EN
      checks++;
      if (rx_word_total !== 16'(m_total)) begin errors++; $display("FAIL rand_total_%0d got=%0d exp=%0d", i, rx_word_total, m_total); end
`endif
    end
  endtask
`ifdef PHY_RX_FIFO_STATS_EN
  task automatic test_stats();
    step(1, 0, 0, 0);
    for (int i = 0; i < D + 1; i++) step(0, 1, i, 0);
    checks++;
    if (rx_word_total !== 16'd8) begin errors++; $display("FAIL stats_total got=%0d exp=8", rx_word_total); end
  endtask
`endif
  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_link();
`ifdef PHY_RX_FIFO_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
